// File: rtl/sync_lock_ctrl.sv
// Frame-lock controller: measures source lines per frame, runs the lock FSM and drives
// timing-generator resync and pattern select. Optional macro AUTO_POLARITY_EN adds sync polarity detection.

`ifdef AUTO_POLARITY_EN
// Per-input polarity detector: 2^20-cycle windows, active-high when the input is mostly low.
module sync_lock_pol (
   input  logic clk25,
   input  logic reset_n,
   input  logic level,
   output logic pol,
   output logic changed
);

   logic [19:0] win_tmr;
   logic [19:0] hi_cnt;
   logic [20:0] hi_total;
   logic        pol_new;

   assign hi_total = {1'b0, hi_cnt} + {20'b0, level};
   assign pol_new  = (hi_total < 21'h80000);

   always_ff @(posedge clk25 or negedge reset_n) begin
      if (!reset_n) begin
         win_tmr <= '1;
         hi_cnt  <= '0;
         pol     <= 1'b0;
         changed <= 1'b0;
      end else begin
         changed <= 1'b0;
         if (win_tmr == '0) begin
            win_tmr <= '1;
            hi_cnt  <= '0;
            if (pol_new != pol) begin
               pol     <= pol_new;
               changed <= 1'b1;
            end
         end else begin
            win_tmr <= win_tmr - 20'd1;
            hi_cnt  <= hi_cnt + {19'b0, level};
         end
      end
   end

endmodule
`endif

// state    | meaning
// NOSYNC   | no valid source; test pattern shown, waiting for an in-range frame
// ACQUIRE  | reference frame captured; counting consecutive matching frames
// LOCKED   | source tracked; generator resynced on every matching frame
// HOLD     | one bad frame seen; generator freewheels, one good frame relocks
module sync_lock_ctrl #(
   parameter int LINES_MIN   = 200,
   parameter int LINES_MAX   = 1000,
   parameter int LINE_TOL    = 2,
   parameter int LOCK_FRAMES = 4,
   parameter int H_TIMEOUT   = 4095
) (
   input  logic       clk25,
   input  logic       reset_n,
   input  logic       HSYNC_in,
   input  logic       VSYNC_in,
   output logic       resync,
   output logic       test_pattern,
   output logic       locked,
   output logic [9:0] lines_per_frame,
   output logic [1:0] state,
   output logic       hs_pol,
   output logic       vs_pol
);

   typedef enum logic [1:0] {
      ST_NOSYNC  = 2'd0,
      ST_ACQUIRE = 2'd1,
      ST_LOCKED  = 2'd2,
      ST_HOLD    = 2'd3
   } state_t;

   localparam logic [11:0] H_TC      = 12'(H_TIMEOUT);
   localparam logic [10:0] L_MIN     = 11'(LINES_MIN);
   localparam logic [10:0] L_MAX     = 11'(LINES_MAX);
   localparam logic [11:0] L_TOL     = 12'(LINE_TOL);
   localparam logic [3:0]  MCNT_LOCK = 4'(LOCK_FRAMES - 1);

   state_t             state_q, state_d;
   logic [1:0]         hs_sync, vs_sync;
   logic               hs_d, vs_d;
   logic               hs_edge, vs_edge;
   logic               hs_pol_chg, vs_pol_chg, pol_chg;
   logic [10:0]        line_cnt;
   logic [11:0]        h_tmr;
   logic               hs_lost, v_over;
   logic [9:0]         ref_q, ref_d;
   logic [3:0]         mcnt_q, mcnt_d;
   logic [3:0]         mcnt_inc;
   logic [9:0]         lpf_d;
   logic               resync_d;
   logic               locked_d;
   logic signed [11:0] line_diff;
   logic [11:0]        line_dev;
   logic               match, in_range;

`ifdef AUTO_POLARITY_EN
   sync_lock_pol u_hs_pol (
      .clk25   (clk25),
      .reset_n (reset_n),
      .level   (hs_sync[1]),
      .pol     (hs_pol),
      .changed (hs_pol_chg)
   );

   sync_lock_pol u_vs_pol (
      .clk25   (clk25),
      .reset_n (reset_n),
      .level   (vs_sync[1]),
      .pol     (vs_pol),
      .changed (vs_pol_chg)
   );
`else
   assign hs_pol     = 1'b0;
   assign vs_pol     = 1'b0;
   assign hs_pol_chg = 1'b0;
   assign vs_pol_chg = 1'b0;
`endif

   assign pol_chg = hs_pol_chg | vs_pol_chg;

   // Edge pulse is registered: input change to pulse is three clocks.
   always_ff @(posedge clk25 or negedge reset_n) begin
      if (!reset_n) begin
         hs_sync <= '0;
         vs_sync <= '0;
         hs_d    <= 1'b0;
         vs_d    <= 1'b0;
         hs_edge <= 1'b0;
         vs_edge <= 1'b0;
      end else begin
         hs_sync <= {hs_sync[0], HSYNC_in};
         vs_sync <= {vs_sync[0], VSYNC_in};
         hs_d    <= hs_sync[1];
         vs_d    <= vs_sync[1];
         hs_edge <= (hs_sync[1] == hs_pol) && (hs_d != hs_pol);
         vs_edge <= (vs_sync[1] == vs_pol) && (vs_d != vs_pol);
      end
   end

   always_ff @(posedge clk25 or negedge reset_n) begin
      if (!reset_n) begin
         line_cnt <= '0;
      end else if (pol_chg || vs_edge) begin
         line_cnt <= '0;
      end else if (hs_edge && (line_cnt != 11'h7ff)) begin
         line_cnt <= line_cnt + 11'd1;
      end
   end

   // Line-period watchdog: down-counter reloaded by each hsync, terminal count means hsync lost.
   always_ff @(posedge clk25 or negedge reset_n) begin
      if (!reset_n) begin
         h_tmr <= H_TC;
      end else if (pol_chg || hs_edge) begin
         h_tmr <= H_TC;
      end else if (h_tmr != '0) begin
         h_tmr <= h_tmr - 12'd1;
      end
   end

   assign hs_lost   = (h_tmr == '0);
   assign v_over    = (line_cnt > L_MAX);
   assign line_diff = $signed({1'b0, line_cnt}) - $signed({2'b00, ref_q});
   assign line_dev  = line_diff[11] ? $unsigned(-line_diff) : $unsigned(line_diff);
   assign match     = (line_dev <= L_TOL);
   assign in_range  = (line_cnt >= L_MIN) && (line_cnt <= L_MAX);
   assign mcnt_inc  = mcnt_q + 4'd1;

   always_comb begin
      state_d  = state_q;
      ref_d    = ref_q;
      mcnt_d   = mcnt_q;
      lpf_d    = lines_per_frame;
      resync_d = 1'b0;
      if (pol_chg) begin
         state_d = ST_NOSYNC;
      end else if ((state_q != ST_NOSYNC) && (hs_lost || v_over)) begin
         state_d = ST_NOSYNC;
      end else if (vs_edge) begin
         case (state_q)
            ST_NOSYNC: begin
               if (in_range) begin
                  ref_d   = line_cnt[9:0];
                  mcnt_d  = '0;
                  state_d = ST_ACQUIRE;
               end
            end
            ST_ACQUIRE: begin
               if (match) begin
                  mcnt_d = mcnt_inc;
                  if (mcnt_inc == MCNT_LOCK) begin
                     state_d  = ST_LOCKED;
                     resync_d = 1'b1;
                     lpf_d    = line_cnt[9:0];
                  end
               end else if (in_range) begin
                  ref_d  = line_cnt[9:0];
                  mcnt_d = '0;
               end else begin
                  state_d = ST_NOSYNC;
               end
            end
            ST_LOCKED: begin
               if (match) begin
                  resync_d = 1'b1;
                  lpf_d    = line_cnt[9:0];
               end else begin
                  state_d = ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (match) begin
                  state_d  = ST_LOCKED;
                  resync_d = 1'b1;
                  lpf_d    = line_cnt[9:0];
               end else begin
                  state_d = ST_NOSYNC;
               end
            end
            default: state_d = ST_NOSYNC;
         endcase
      end
   end

   assign locked_d = (state_d == ST_LOCKED) || (state_d == ST_HOLD);

   always_ff @(posedge clk25 or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= ST_NOSYNC;
         ref_q           <= '0;
         mcnt_q          <= '0;
         lines_per_frame <= '0;
         resync          <= 1'b0;
         locked          <= 1'b0;
         test_pattern    <= 1'b1;
      end else begin
         state_q         <= state_d;
         ref_q           <= ref_d;
         mcnt_q          <= mcnt_d;
         lines_per_frame <= lpf_d;
         resync          <= resync_d;
         locked          <= locked_d;
         test_pattern    <= !locked_d;
      end
   end

   assign state = state_q;

endmodule
